// File: rtl/axis_arbiter_2.sv
// Two-input AXI-Stream arbiter, packet-granular round-robin, one registered output stage.
// Latency: 1 cycle from input handshake to output_valid. Inputs stall whenever the stage holds an unaccepted beat.
module axis_arbiter_2 #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  input_0_valid,
    input  logic                  input_0_last,
    input  logic [DATA_WIDTH-1:0] input_0_data,
    output logic                  input_0_ready,

    input  logic                  input_1_valid,
    input  logic                  input_1_last,
    input  logic [DATA_WIDTH-1:0] input_1_data,
    output logic                  input_1_ready,

    output logic                  output_valid,
    output logic                  output_last,
    output logic                  output_sel,
    output logic [DATA_WIDTH-1:0] output_data,
    input  logic                  output_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_0 = 2'd1,
        LOCK_1 = 2'd2
    } state_t;

    state_t                state_q;
    logic                  prio_q;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic                  out_sel_q;
    logic [DATA_WIDTH-1:0] out_data_q;

    logic                  stage_free;
    logic                  grant_vld;
    logic                  grant_sel;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  xfer;

    assign stage_free = !out_valid_q || output_ready;

    // A locked requester keeps the grant even while its valid is low, so packets never interleave.
    always_comb begin
        grant_vld = 1'b0;
        grant_sel = 1'b0;
        case (state_q)
            IDLE: begin
                if (input_0_valid && input_1_valid) begin
                    grant_vld = 1'b1;
                    grant_sel = prio_q;
                end else if (input_0_valid) begin
                    grant_vld = 1'b1;
                    grant_sel = 1'b0;
                end else if (input_1_valid) begin
                    grant_vld = 1'b1;
                    grant_sel = 1'b1;
                end
            end
            LOCK_0: begin
                grant_vld = 1'b1;
                grant_sel = 1'b0;
            end
            LOCK_1: begin
                grant_vld = 1'b1;
                grant_sel = 1'b1;
            end
            default: begin
                grant_vld = 1'b0;
                grant_sel = 1'b0;
            end
        endcase
    end

    assign sel_valid = grant_sel ? input_1_valid : input_0_valid;
    assign sel_last  = grant_sel ? input_1_last  : input_0_last;
    assign sel_data  = grant_sel ? input_1_data  : input_0_data;

    assign input_0_ready = !rst && stage_free && grant_vld && !grant_sel;
    assign input_1_ready = !rst && stage_free && grant_vld &&  grant_sel;
    assign xfer          = !rst && stage_free && grant_vld && sel_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_sel_q   <= 1'b0;
            out_data_q  <= '0;
        end else if (stage_free) begin
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_last_q  <= sel_last;
                out_sel_q   <= grant_sel;
                out_data_q  <= sel_data;
                if (sel_last) begin
                    state_q <= IDLE;
                    prio_q  <= ~grant_sel;
                end else begin
                    state_q <= grant_sel ? LOCK_1 : LOCK_0;
                end
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign output_valid = out_valid_q;
    assign output_last  = out_last_q;
    assign output_sel   = out_sel_q;
    assign output_data  = out_data_q;

endmodule

// File: tb/tb_axis_arbiter_2.sv
// Bench for axis_arbiter_2: fixed vector table, directed corner sequences, random traffic vs. a reference model.
module tb_axis_arbiter_2;

    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic          input_0_valid, input_0_last, input_0_ready;
    logic [DW-1:0] input_0_data;
    logic          input_1_valid, input_1_last, input_1_ready;
    logic [DW-1:0] input_1_data;
    logic          output_valid, output_last, output_sel, output_ready;
    logic [DW-1:0] output_data;

    int total = 0;
    int bad   = 0;

    axis_arbiter_2 #(.DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .input_0_valid (input_0_valid),
        .input_0_last  (input_0_last),
        .input_0_data  (input_0_data),
        .input_0_ready (input_0_ready),
        .input_1_valid (input_1_valid),
        .input_1_last  (input_1_last),
        .input_1_data  (input_1_data),
        .input_1_ready (input_1_ready),
        .output_valid  (output_valid),
        .output_last   (output_last),
        .output_sel    (output_sel),
        .output_data   (output_data),
        .output_ready  (output_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: owner of the current packet (-1 = none), tie-break favourite, and the held beat.
    int            m_owner;
    int            m_prio;
    bit            m_ov;
    bit            m_ol;
    bit            m_os;
    logic [DW-1:0] m_od;

    task automatic m_reset();
        m_owner = -1;
        m_prio  = 0;
        m_ov    = 0;
        m_ol    = 0;
        m_os    = 0;
        m_od    = '0;
    endtask

    function automatic int m_grant();
        if (m_owner >= 0) return m_owner;
        if (input_0_valid && input_1_valid) return m_prio;
        if (input_0_valid) return 0;
        if (input_1_valid) return 1;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1 with inputs already set; returns at the next posedge+1.
    task automatic tick();
        int g;
        bit free;
        bit v;
        #1;
        g    = m_grant();
        free = !m_ov || output_ready;
        check("ready0", input_0_ready, (!rst && free && g == 0));
        check("ready1", input_1_ready, (!rst && free && g == 1));
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else if (free) begin
            v = (g == 0) ? input_0_valid : (g == 1) ? input_1_valid : 1'b0;
            if (g >= 0 && v) begin
                m_ov = 1;
                m_os = (g == 1);
                m_ol = (g == 1) ? input_1_last : input_0_last;
                m_od = (g == 1) ? input_1_data : input_0_data;
                if (m_ol) begin
                    m_owner = -1;
                    m_prio  = 1 - g;
                end else begin
                    m_owner = g;
                end
            end else begin
                m_ov = 0;
            end
        end
        #1;
        check("out_valid", output_valid, m_ov);
        if (m_ov) begin
            check("out_last", output_last, m_ol);
            check("out_sel",  output_sel,  m_os);
            check("out_data", output_data, m_od);
        end
    endtask

    task automatic drive(input bit v0, input bit l0, input logic [DW-1:0] d0,
                         input bit v1, input bit l1, input logic [DW-1:0] d1, input bit ordy);
        input_0_valid = v0; input_0_last = l0; input_0_data = d0;
        input_1_valid = v1; input_1_last = l1; input_1_data = d1;
        output_ready  = ordy;
    endtask

    typedef struct {
        bit            v0, l0;
        logic [DW-1:0] d0;
        bit            v1, l1;
        logic [DW-1:0] d1;
        bit            ordy;
        bit            er0, er1;
        bit            eov, eol, eos;
        logic [DW-1:0] eod;
    } vec_t;

    vec_t vecs[16];

    initial begin
        // v0 l0 d0 | v1 l1 d1 | ordy | ready0 ready1 | out valid last sel data
        vecs[0]  = '{1, 1, 16'hA000, 1, 1, 16'hB000, 1, 1, 0, 1, 1, 0, 16'hA000};
        vecs[1]  = '{1, 1, 16'hA001, 1, 1, 16'hB000, 1, 0, 1, 1, 1, 1, 16'hB000};
        vecs[2]  = '{1, 1, 16'hA001, 1, 1, 16'hB001, 1, 1, 0, 1, 1, 0, 16'hA001};
        vecs[3]  = '{1, 1, 16'hA002, 1, 1, 16'hB001, 1, 0, 1, 1, 1, 1, 16'hB001};
        vecs[4]  = '{1, 0, 16'hC000, 1, 1, 16'hB002, 1, 1, 0, 1, 0, 0, 16'hC000};
        vecs[5]  = '{1, 0, 16'hC001, 1, 1, 16'hB002, 1, 1, 0, 1, 0, 0, 16'hC001};
        vecs[6]  = '{1, 0, 16'hC002, 1, 1, 16'hB002, 1, 1, 0, 1, 0, 0, 16'hC002};
        vecs[7]  = '{1, 1, 16'hC003, 1, 1, 16'hB002, 1, 1, 0, 1, 1, 0, 16'hC003};
        vecs[8]  = '{1, 1, 16'hD000, 1, 1, 16'hB002, 1, 0, 1, 1, 1, 1, 16'hB002};
        vecs[9]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000};
        vecs[10] = '{0, 0, 16'h0000, 1, 0, 16'hE000, 1, 0, 1, 1, 0, 1, 16'hE000};
        vecs[11] = '{1, 1, 16'hF000, 1, 1, 16'hE001, 1, 0, 1, 1, 1, 1, 16'hE001};
        vecs[12] = '{1, 1, 16'hF000, 0, 0, 16'h0000, 0, 0, 0, 1, 1, 1, 16'hE001};
        vecs[13] = '{1, 1, 16'hF000, 0, 0, 16'h0000, 1, 1, 0, 1, 1, 0, 16'hF000};
        vecs[14] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1, 1, 0, 16'hF000};
        vecs[15] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000};

        // Reset with both requesters asserting valid: everything must be quiet.
        rst = 1'b1;
        drive(1, 1, 16'h1234, 1, 1, 16'h5678, 1);
        m_reset();
        #2;
        check("rst_valid", output_valid, 0);
        check("rst_last",  output_last,  0);
        check("rst_sel",   output_sel,   0);
        check("rst_data",  output_data,  0);
        check("rst_rdy0",  input_0_ready, 0);
        check("rst_rdy1",  input_1_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].v0, vecs[i].l0, vecs[i].d0, vecs[i].v1, vecs[i].l1, vecs[i].d1, vecs[i].ordy);
            #1;
            check($sformatf("vec%0d_rdy0", i), input_0_ready, vecs[i].er0);
            check($sformatf("vec%0d_rdy1", i), input_1_ready, vecs[i].er1);
            tick();
            check($sformatf("vec%0d_valid", i), output_valid, vecs[i].eov);
            if (vecs[i].eov) begin
                check($sformatf("vec%0d_last", i), output_last, vecs[i].eol);
                check($sformatf("vec%0d_sel", i),  output_sel,  vecs[i].eos);
                check($sformatf("vec%0d_data", i), output_data, vecs[i].eod);
            end
        end

        // Asynchronous reset in the middle of a 3-beat packet from input 0.
        drive(1, 0, 16'h6000, 0, 0, 16'h0000, 1);
        tick();
        drive(1, 0, 16'h6001, 1, 1, 16'h7000, 1);
        check("arst_pre_valid", output_valid, 1);
        rst = 1'b1;
        #1;
        check("arst_valid_drop", output_valid, 0);
        check("arst_rdy0", input_0_ready, 0);
        check("arst_rdy1", input_1_ready, 0);
        rst = 1'b0;
        m_reset();
        drive(1, 1, 16'h6100, 1, 1, 16'h7000, 1);
        tick();
        check("arst_tie_sel",  output_sel,  0);
        check("arst_tie_data", output_data, 16'h6100);

        // Locked input 0 goes quiet for 3 cycles; input 1 must not sneak in.
        drive(1, 0, 16'h8000, 0, 0, 16'h0000, 1);
        tick();
        drive(0, 0, 16'h0000, 1, 1, 16'h9000, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gap_rdy1", input_1_ready, 0);
            check("gap_valid", output_valid, 0);
        end
        drive(1, 1, 16'h8001, 1, 1, 16'h9000, 1);
        tick();
        check("gap_end_sel",  output_sel,  0);
        check("gap_end_data", output_data, 16'h8001);
        drive(0, 0, 16'h0000, 1, 1, 16'h9000, 1);
        tick();
        check("gap_next_sel",  output_sel,  1);
        check("gap_next_data", output_data, 16'h9000);

        // Output stalled for 5 cycles with both inputs pending.
        drive(1, 1, 16'hA100, 1, 1, 16'hB100, 1);
        tick();
        check("stall_first", output_data, 16'hA100);
        output_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", output_valid, 1);
            check("stall_data",  output_data,  16'hA100);
            check("stall_sel",   output_sel,   0);
            check("stall_rdy0",  input_0_ready, 0);
            check("stall_rdy1",  input_1_ready, 0);
        end
        output_ready = 1'b1;
        tick();
        check("stall_after_sel",  output_sel,  1);
        check("stall_after_data", output_data, 16'hB100);
        drive(0, 0, 16'h0000, 0, 0, 16'h0000, 1);
        tick();
        check("stall_drain", output_valid, 0);

        // Only input 1 active with 2-beat packets: no slots reserved for input 0.
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 16'h0000, 1, i[0], 16'hC100 + DW'(i), 1);
            tick();
            check("solo1_valid", output_valid, 1);
            check("solo1_sel",   output_sel,   1);
            check("solo1_data",  output_data,  16'hC100 + DW'(i));
        end

        // Random traffic, random backpressure, occasional asynchronous reset.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, DW'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, DW'($urandom),
                  $urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
